// File: rtl/uart_rx_oversampled_if.sv
// Receive-side bundle for uart_rx_oversampled: oversample tick and serial line in,
// received byte and frame status out.
interface uart_rx_oversampled_if #(
  parameter int DATA_BITS = 8
);
  logic                 Tick;
  logic                 RxD;
  logic [DATA_BITS-1:0] RxData;
  logic                 RxDone;
  logic                 FrameErr;
  logic                 ParityErr;
  logic                 Busy;

  modport master (output Tick, RxD, input RxData, RxDone, FrameErr, ParityErr, Busy);
  modport slave  (input Tick, RxD, output RxData, RxDone, FrameErr, ParityErr, Busy);
endinterface

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver, 8N1 by default; define UART_RX_PARITY_EN for an
// even-parity bit between the data bits and the stop bit (8E1).
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  uart_rx_oversampled_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_n;
  logic                 rx_meta, rx_s;
  logic [TW-1:0]        tcnt_q, tcnt_n;
  logic [BW-1:0]        bcnt_q, bcnt_n;
  logic [DATA_BITS-1:0] sh_q, sh_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic                 done_q, done_n;
  logic                 ferr_q, ferr_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_n;
  logic                 perr_q, perr_n;

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction
`endif

  always_comb begin
    state_n = state_q;
    tcnt_n  = tcnt_q;
    bcnt_n  = bcnt_q;
    sh_n    = sh_q;
    data_n  = data_q;
    ferr_n  = ferr_q;
    done_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_q;
    perr_n  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        // A low line starts the half-bit count without waiting for a tick.
        if (!rx_s) begin
          state_n = START;
          tcnt_n  = '0;
        end
      end
      START: begin
        if (bus.Tick) begin
          if (tcnt_q == T_MID) begin
            tcnt_n  = '0;
            bcnt_n  = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            tcnt_n = tcnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.Tick) begin
          if (tcnt_q == T_LAST) begin
            tcnt_n = '0;
            sh_n   = {rx_s, sh_q[DATA_BITS-1:1]};
            bcnt_n = bcnt_q + 1'b1;
            if (bcnt_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end else begin
            tcnt_n = tcnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bus.Tick) begin
          if (tcnt_q == T_LAST) begin
            tcnt_n  = '0;
            par_n   = rx_s;
            state_n = STOP;
          end else begin
            tcnt_n = tcnt_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        // Back to IDLE at mid-stop so a start bit right behind it is not missed.
        if (bus.Tick) begin
          if (tcnt_q == T_LAST) begin
            tcnt_n  = '0;
            data_n  = sh_q;
            ferr_n  = ~rx_s;
            done_n  = 1'b1;
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            perr_n  = parity_mismatch(sh_q, par_q);
`endif
          end else begin
            tcnt_n = tcnt_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      rx_meta <= bus.RxD;
      rx_s    <= rx_meta;
      state_q <= state_n;
      tcnt_q  <= tcnt_n;
      bcnt_q  <= bcnt_n;
      sh_q    <= sh_n;
      data_q  <= data_n;
      done_q  <= done_n;
      ferr_q  <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_n;
      perr_q  <= perr_n;
`endif
    end
  end

  assign bus.RxData   = data_q;
  assign bus.RxDone   = done_q;
  assign bus.FrameErr = ferr_q;
  assign bus.Busy     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.ParityErr = perr_q;
`else
  assign bus.ParityErr = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: directed and random frames against a frame-level model.
module tb_uart_rx_oversampled;
  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 4;
  localparam int BIT_CLK    = OVERSAMPLE * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 ferr;
    logic                 perr;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst;
  uart_rx_oversampled_if #(.DATA_BITS(DATA_BITS)) bus ();

  uart_rx_oversampled #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  exp_t                 exp_q[$];
  logic [DATA_BITS-1:0] exp_last = '0;
  int                   n_vec    = 0;
  int                   n_err    = 0;
  int                   n_done   = 0;
  int                   n_sent   = 0;
  logic                 done_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Oversample strobe: one Clk wide, every TICK_DIV clocks.
  initial begin
    int tdiv = 0;
    bus.Tick = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      tdiv = (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
      bus.Tick = (tdiv == 0);
    end
  end

  // Each RxDone pulse must match the oldest frame sent and not yet delivered.
  always @(negedge Clk) begin
    if (bus.RxDone) begin
      exp_t e;
      n_done++;
      chk("done_width", {31'b0, done_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rxdata", {24'b0, bus.RxData}, {24'b0, e.data});
        chk("frame_err", {31'b0, bus.FrameErr}, {31'b0, e.ferr});
        chk("parity_err", {31'b0, bus.ParityErr}, {31'b0, e.perr});
        chk("busy_at_done", {31'b0, bus.Busy}, 32'd0);
      end
    end
    done_prev = bus.RxDone;
  end

  // A bad stop bit is held low for 3/4 of a bit and followed by one idle bit, so the
  // receiver's re-armed start check lands on a high line.
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit stop_ok, input bit par_ok);
    exp_t e;
    e.data = d;
    e.ferr = !stop_ok;
    e.perr = PAR_EN && !par_ok;
    exp_q.push_back(e);
    exp_last = d;
    n_sent++;
    bus.RxD = 1'b0;
    hold(BIT_CLK);
    for (int i = 0; i < DATA_BITS; i++) begin
      bus.RxD = d[i];
      hold(BIT_CLK);
    end
    chk("busy_in_frame", {31'b0, bus.Busy}, 32'd1);
    if (PAR_EN) begin
      bus.RxD = (^d) ^ !par_ok;
      hold(BIT_CLK);
    end
    if (stop_ok) begin
      bus.RxD = 1'b1;
      hold(BIT_CLK);
    end else begin
      bus.RxD = 1'b0;
      hold(BIT_CLK * 3 / 4);
      bus.RxD = 1'b1;
      hold(BIT_CLK - BIT_CLK * 3 / 4 + BIT_CLK);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 4 * 12 * BIT_CLK) begin
      @(posedge Clk);
      n++;
    end
    #1;
    chk(tag, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rxdata"}, {24'b0, bus.RxData}, 32'd0);
    chk({tag, "_rxdone"}, {31'b0, bus.RxDone}, 32'd0);
    chk({tag, "_frameerr"}, {31'b0, bus.FrameErr}, 32'd0);
    chk({tag, "_parityerr"}, {31'b0, bus.ParityErr}, 32'd0);
    chk({tag, "_busy"}, {31'b0, bus.Busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base;
    Rst     = 1'b1;
    bus.RxD = 1'b1;
    hold(3);
    check_reset_outputs("in_reset");
    Rst = 1'b0;
    hold(4);
    check_reset_outputs("after_reset");
    hold(20);

    // Glitch of 5 ticks: no frame, data still at its reset value.
    base = n_done;
    bus.RxD = 1'b0;
    hold(5 * TICK_DIV);
    bus.RxD = 1'b1;
    hold(3 * BIT_CLK);
    chk("glitch_done", n_done - base, 32'd0);
    chk("glitch_data", {24'b0, bus.RxData}, {24'b0, exp_last});
    chk("glitch_busy", {31'b0, bus.Busy}, 32'd0);

    send_frame(8'hA5, 1'b1, 1'b1);
    drain("drain_a5");
    chk("idle_after_a5", {31'b0, bus.Busy}, 32'd0);

    hold(37);
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1);
    drain("drain_ferr");

    base = n_done;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    drain("drain_b2b");
    chk("b2b_count", n_done - base, 32'd3);

    // Reset in the middle of data bit 4 of 0x81.
    base = n_done;
    bus.RxD = 1'b0;
    hold(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      bus.RxD = (i == 0);
      hold(BIT_CLK);
    end
    bus.RxD = 1'b0;
    hold(BIT_CLK / 2);
    Rst = 1'b1;
    bus.RxD = 1'b1;
    #1;
    exp_last = '0;
    check_reset_outputs("midframe_rst");
    hold(2);
    Rst = 1'b0;
    hold(2 * BIT_CLK);
    chk("midframe_done", n_done - base, 32'd0);
    check_reset_outputs("post_rst");
    send_frame(8'h7E, 1'b1, 1'b1);
    drain("drain_7e");

    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    drain("drain_parity");

    for (int k = 0; k < 24; k++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 150);
      if (gap > 0) begin
        bus.RxD = 1'b1;
        hold(gap);
      end
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
    end
    drain("drain_random");
    hold(BIT_CLK);
    chk("done_total", n_done, n_sent);
    chk("final_data", {24'b0, bus.RxData}, {24'b0, exp_last});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
UART receiver that consumes the 16x-oversampling Tick from the baud-rate generator. It recovers 8N1 frames (optionally 8E1) from the asynchronous serial line RxD. Each received byte is presented with a single-cycle RxDone strobe and frame-error status. Sits between the pad-side RxD pin and the byte-oriented consumer logic, in the same Clk domain as the baud-rate generator.

Parameters:
DATA_BITS, 8, number of data bits per frame, LSB first (legal 5..8)
OVERSAMPLE, 16, Tick pulses per bit period; counter width = $clog2(OVERSAMPLE)

Ports:
Clk  input  1  system clock; all logic on posedge
Rst  input  1  asynchronous, active-high reset
Tick  input  1  oversample strobe from the baud-rate generator, 1 Clk cycle wide, OVERSAMPLE per bit
RxD  input  1  asynchronous serial line, idle high
RxData  output  DATA_BITS  last received byte, held until the next frame completes
RxDone  output  1  one-Clk-cycle pulse when RxData/FrameErr/ParityErr update
FrameErr  output  1  stop bit sampled 0 for the last frame; updated with RxDone
ParityErr  output  1  parity mismatch on the last frame (see Optional Feature)
Busy  output  1  high whenever state != IDLE

Behaviour:
- Clocking: one clock, Clk. Reset is asynchronous and active-high on Rst. Every register clears on Rst assertion, independent of Clk.
- Reset values: RxData=0, RxDone=0, FrameErr=0, ParityErr=0, Busy=0, state=IDLE, tick counter=0, bit counter=0, synchronizer flops=1.
- RxD passes through a 2-flop synchronizer (rx_s). All decisions below use rx_s.
- Tick counter (tcnt) advances only on Clk cycles where Tick=1. Bit counter (bcnt) counts data bits.
- States:
  - IDLE: when rx_s=0, go to START with tcnt=0 (no Tick required to enter).
  - START: on Tick with tcnt==OVERSAMPLE/2-1 (mid start bit), check rx_s:
    - rx_s=0: go to DATA, tcnt=0, bcnt=0.
    - rx_s=1: false start (glitch); go to IDLE with no RxDone.
    - Otherwise on Tick, tcnt++.
  - DATA: on Tick with tcnt==OVERSAMPLE-1, shift rx_s into shift reg MSB (right shift, LSB first), tcnt=0, bcnt++.
    - After bit DATA_BITS-1, go to PARITY (macro on) or STOP.
    - Otherwise on Tick, tcnt++.
  - PARITY: same sampling point as DATA; capture the parity bit, then go to STOP.
  - STOP: on Tick with tcnt==OVERSAMPLE-1, sample the stop bit, then:
    - RxData<=shift reg; FrameErr<=~rx_s; ParityErr updated; RxDone<=1 for exactly one Clk; go to IDLE.
- Sampling/latency: every sample is taken at mid-bit (OVERSAMPLE/2 ticks after the detected falling edge, plus whole bit periods).
- RxDone asserts on the Clk edge after the Tick that samples mid-stop. RxDone and the data outputs update on that same edge.
- Frame error: on stop=0, data is still delivered and FrameErr=1. The receiver returns to IDLE and, if rx_s stays 0, immediately starts a new frame (break condition yields repeated FrameErr frames containing 0x00).
- Back-to-back frames: because the receiver is in IDLE from mid-stop, a start bit immediately following the stop bit is detected with no lost frame.
- No flow control: if the consumer misses RxDone, RxData is overwritten on the next frame (no overrun flag).
- Rst mid-frame: abort immediately, all outputs return to reset values, no RxDone.
- Tick low for arbitrary cycles freezes all counters; Tick=1 on consecutive Clk cycles is legal.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: frame is start + DATA_BITS + even-parity bit + stop. PARITY state is present. ParityErr <= (XOR of data bits) ^ parity bit, updated with RxDone.
- Undefined: PARITY state is absent, ParityErr is tied to 0, and the frame is start + DATA_BITS + stop.

Test Plan:
- Tick every 4 Clk (OVERSAMPLE=16); drive 8N1 frame 0xA5 at 64 Clk per bit -> exactly one RxDone pulse, RxData=0xA5, FrameErr=0, Busy low after mid-stop.
- RxD low for 5 Ticks then high (glitch) -> returns to IDLE, no RxDone, RxData unchanged (0x00 after reset).
- Frame 0x3C with stop bit driven 0 -> RxDone pulse, RxData=0x3C, FrameErr=1. A following clean frame 0x01 -> FrameErr=0, RxData=0x01.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three RxDone pulses carrying those values in order.
- Assert Rst for 2 Clk midway through data bit 4 of 0x81 -> outputs at reset values, no RxDone. The next frame 0x7E is received correctly.
- With UART_RX_PARITY_EN: frame 0x07 with parity 1 -> ParityErr=0; same data with parity 0 -> ParityErr=1. Without the macro, ParityErr stays 0 throughout all tests.
